// File: rtl/api_rx_parse.sv
// RX reply parser: drains the RX FIFO in fixed 4-word blocks, validates the magic word and
// forwards nonce-carrying blocks on a valid/ready result port while counting blank/bad blocks.
`timescale 1ns/1ps

module api_rx_parse #(
  parameter int          BLK_LEN = 4,
  parameter logic [15:0] MAGIC   = 16'hA55A,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cnt_clr,
  input  logic             rx_fifo_empty,
  output logic             rx_fifo_rd_en,
  input  logic [31:0]      rx_fifo_dout,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [31:0]      res_nonce,
  output logic [15:0]      res_job,
  output logic [7:0]       res_chip,
  output logic [31:0]      res_info,
  output logic [CNT_W-1:0] nonce_cnt,
  output logic [CNT_W-1:0] blank_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int IDX_W = $clog2(BLK_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CHK,
    S_OUT
  } state_e;

  state_e             state_q,     state_d;
  logic [IDX_W-1:0]   rd_idx_q,    rd_idx_d;
  logic [IDX_W-1:0]   cap_idx_q,   cap_idx_d;
  logic               cap_vld_q,   cap_vld_d;
  logic               res_vld_q,   res_vld_d;
  logic [31:0]        res_nonce_q, res_nonce_d;
  logic [15:0]        res_job_q,   res_job_d;
  logic [7:0]         res_chip_q,  res_chip_d;
  logic [31:0]        res_info_q,  res_info_d;
  logic [CNT_W-1:0]   nonce_cnt_q, nonce_cnt_d;
  logic [CNT_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;
  logic               nonce_inc, blank_inc, err_inc;

  // Captured block fields; only the bits the parser consumes are kept.
  logic [31:0] w_nonce_q;
  logic [15:0] w_job_q;
  logic [7:0]  w_chip_q;
  logic        w_flag_q;
  logic [31:0] w_info_q;
  logic [15:0] w_magic_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    return (inc && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  endfunction

  assign rx_fifo_rd_en = (state_q == S_READ) && !rx_fifo_empty && (rd_idx_q < IDX_W'(BLK_LEN));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    cap_idx_d   = cap_idx_q;
    cap_vld_d   = rx_fifo_rd_en;
    res_vld_d   = res_vld_q;
    res_nonce_d = res_nonce_q;
    res_job_d   = res_job_q;
    res_chip_d  = res_chip_q;
    res_info_d  = res_info_q;
    nonce_inc   = 1'b0;
    blank_inc   = 1'b0;
    err_inc     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en && !rx_fifo_empty) begin
          state_d   = S_READ;
          rd_idx_d  = '0;
          cap_idx_d = '0;
        end
      end
      S_READ: begin
        if (rx_fifo_rd_en) rd_idx_d = rd_idx_q + IDX_W'(1);
        // Data lags the strobe by one cycle; the last capture closes the block.
        if (cap_vld_q) begin
          cap_idx_d = cap_idx_q + IDX_W'(1);
          if (cap_idx_q == IDX_W'(BLK_LEN - 1)) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (w_magic_q != MAGIC) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else if (w_flag_q) begin
          res_vld_d   = 1'b1;
          res_nonce_d = w_nonce_q;
          res_job_d   = w_job_q;
          res_chip_d  = w_chip_q;
          res_info_d  = w_info_q;
          state_d     = S_OUT;
        end else begin
          blank_inc = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_OUT: begin
        if (res_rdy) begin
          res_vld_d = 1'b0;
          nonce_inc = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    nonce_cnt_d = cnt_clr ? '0 : sat_inc(nonce_cnt_q, nonce_inc);
    blank_cnt_d = cnt_clr ? '0 : sat_inc(blank_cnt_q, blank_inc);
    err_cnt_d   = cnt_clr ? '0 : sat_inc(err_cnt_q, err_inc);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_idx_q    <= '0;
      cap_idx_q   <= '0;
      cap_vld_q   <= 1'b0;
      res_vld_q   <= 1'b0;
      res_nonce_q <= '0;
      res_job_q   <= '0;
      res_chip_q  <= '0;
      res_info_q  <= '0;
      nonce_cnt_q <= '0;
      blank_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      cap_idx_q   <= cap_idx_d;
      cap_vld_q   <= cap_vld_d;
      res_vld_q   <= res_vld_d;
      res_nonce_q <= res_nonce_d;
      res_job_q   <= res_job_d;
      res_chip_q  <= res_chip_d;
      res_info_q  <= res_info_d;
      nonce_cnt_q <= nonce_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // NOTE: block storage has no reset; every field is rewritten before CHK ever reads it.
  always_ff @(posedge clk) begin
    if (cap_vld_q) begin
      case (cap_idx_q)
        IDX_W'(0): w_nonce_q <= rx_fifo_dout;
        IDX_W'(1): begin
          w_job_q  <= rx_fifo_dout[31:16];
          w_chip_q <= rx_fifo_dout[15:8];
          w_flag_q <= rx_fifo_dout[0];
        end
        IDX_W'(2): w_info_q  <= rx_fifo_dout;
        default:   w_magic_q <= rx_fifo_dout[15:0];
      endcase
    end
  end

  assign res_vld   = res_vld_q;
  assign res_nonce = res_nonce_q;
  assign res_job   = res_job_q;
  assign res_chip  = res_chip_q;
  assign res_info  = res_info_q;
  assign nonce_cnt = nonce_cnt_q;
  assign blank_cnt = blank_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule
